puf_resp_framer: RTL and testbench
==================================

Name:
puf_resp_framer

Overview:
- Parametrised host-side response framer for the PUF SoC. It sits between the PUF array (multi-channel response capture) and the host TX byte interface.
- Captures one challenge plus NUM_CH per-channel responses and builds a byte frame: header, mode/sequence, challenge, payload, XOR checksum.
- Streams the frame out with valid/ready.
- Successor to the single-channel fixed-mode framing: adds channel count, field widths, a debug mode carrying raw per-channel data, a wrapping frame sequence number and abort.

Parameters:
- NUM_CH, 4, number of PUF response channels (1..8).
- CHAL_W, 16, challenge width in bits (multiple of 8).
- RESP_W, 16, per-channel response width in bits (multiple of 8).
- CNT_W, 5, frame sequence counter width (1..7).
- HDR_BYTE, 8'hA5, frame header constant.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  capture request.
- in_ready  out  1  framer idle, can capture.
- in_debug  in  1  mode for this frame: 0 normal, 1 debug.
- in_chal  in  CHAL_W  challenge.
- in_resp  in  NUM_CH*RESP_W  responses; ch0 in the LSBs.
- soft_clr  in  1  synchronous abort.
- out_data  out  8  frame byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  host accepts byte.
- frame_done  out  1  one-cycle pulse on acceptance of the checksum byte.
- seq  out  CNT_W  sequence number of the next frame.

Behaviour:
- Reset (async, rst_n low), all outputs: in_ready=1, out_valid=0, out_data=0, frame_done=0, seq=0; FSM in IDLE; byte index=0; checksum=0.
- FSM states: IDLE, SEND, CKSUM.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register in_debug, in_chal and in_resp.
  - Normal mode registers the XOR of all channels, RESP_W bits wide.
  - Go to SEND.
- Latency: capture at edge T; the header is on out_data with out_valid=1 from cycle T+1.
- Normal frame order: HDR_BYTE; mode byte {1'b0, seq zero-extended to 7 bits}; challenge bytes, MSB first; XORed response bytes, MSB first; checksum.
  - Length = 3 + CHAL_W/8 + RESP_W/8.
- Debug frame order: HDR_BYTE; mode byte {1'b1, seq}; challenge, MSB first; ch0..ch(NUM_CH-1) raw responses, each MSB first; checksum.
  - Length = 3 + CHAL_W/8 + NUM_CH*RESP_W/8.
- SEND:
  - The byte index advances only on out_valid&&out_ready.
  - out_data and out_valid are held stable while out_ready=0.
  - The running checksum XORs each accepted byte.
  - After the last payload byte is accepted, go to CKSUM.
- CKSUM:
  - out_data = XOR of all preceding frame bytes, header included.
  - On acceptance: frame_done=1 for one cycle, seq increments (wraps 2^CNT_W-1 -> 0), return to IDLE. in_ready is 1 in the following cycle.
- in_ready=0 in SEND and CKSUM; in_valid is ignored there.
- Back-to-back frames: minimum one IDLE cycle between the checksum acceptance and the next header.
- soft_clr:
  - Any state goes to IDLE next cycle: out_valid=0, index and checksum cleared.
  - seq is not incremented and frame_done is not pulsed.
  - soft_clr in IDLE with in_valid=1: soft_clr wins and no capture occurs.
- Reset mid-frame: immediate return to reset values; seq returns to 0.
- The mode byte carries the seq value at capture time.

Test Plan:
- Normal frame. Stimulus: reset; in_chal=16'h1234, in_resp ch0..ch3=00FF,0F0F,F0F0,1111, in_debug=0, out_ready=1. Response: bytes A5,00,12,34,EE,11,7C; frame_done pulses with the 7C byte; seq=1.
- Debug frame, same data, seq=1. Response: bytes A5,81,12,34,00,FF,0F,0F,F0,F0,11,11,FD.
- Backpressure. Stimulus: drop out_ready for 5 cycles while byte 3 (8'h34) is presented. Response: out_data holds 34 and out_valid stays 1; the frame is otherwise identical and the checksum is unchanged.
- Sequence wrap. Stimulus: 33 back-to-back normal frames. Response: mode bytes run 00..1F then 00; seq=1 at the end; in_valid is never accepted while in_ready=0.
- Abort. Stimulus: assert soft_clr during byte 5 of a debug frame. Response: out_valid=0 next cycle; seq unchanged; no frame_done. The next frame starts with A5 and the same seq.
- Reset mid-frame. Stimulus: pull rst_n low in CKSUM. Response: out_valid=0, seq=0 and in_ready=1 asynchronously.

Source files
------------

// File: rtl/puf_resp_framer.sv
// Frames one challenge plus NUM_CH PUF responses into a checksummed byte stream; header is out one cycle after capture.
// Byte index and checksum advance only on out_valid&&out_ready, so out_data holds while out_ready=0.
module puf_resp_framer #(
   parameter int         NUM_CH   = 4,
   parameter int         CHAL_W   = 16,
   parameter int         RESP_W   = 16,
   parameter int         CNT_W    = 5,
   parameter logic [7:0] HDR_BYTE = 8'hA5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_debug,
   input  logic [CHAL_W-1:0]        in_chal,
   input  logic [NUM_CH*RESP_W-1:0] in_resp,
   input  logic                     soft_clr,
   output logic [7:0]               out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     frame_done,
   output logic [CNT_W-1:0]         seq
);

   localparam int CHAL_B = CHAL_W / 8;
   localparam int RESP_B = RESP_W / 8;
   localparam int PAY_W  = NUM_CH * RESP_W;
   localparam int NORM_N = 2 + CHAL_B + RESP_B;            // bytes before the checksum
   localparam int DBG_N  = 2 + CHAL_B + NUM_CH * RESP_B;
   localparam int BUF_W  = DBG_N * 8;
   localparam int IDX_W  = $clog2(DBG_N);

   typedef enum logic [1:0] {IDLE, SEND, CKSUM} state_t;

   typedef struct packed {
      logic [7:0]        hdr;
      logic [7:0]        mode;
      logic [CHAL_W-1:0] chal;
      logic [PAY_W-1:0]  pay;
   } frame_t;

   state_t            state_q, state_d;
   logic [BUF_W-1:0]  buf_q;
   logic [IDX_W-1:0]  idx_q;
   logic [IDX_W-1:0]  last_idx;
   logic [7:0]        csum_q;
   logic [7:0]        cur_byte;
   logic              dbg_q;
   logic [CNT_W-1:0]  seq_q;
   logic [6:0]        seq7;
   logic [RESP_W-1:0] resp_xor;
   logic [PAY_W-1:0]  dbg_pay;
   logic [PAY_W-1:0]  norm_pay;
   frame_t            cap_frame;
   logic              cap;

   assign seq      = seq_q;
   assign seq7     = 7'(seq_q);
   assign cur_byte = buf_q[BUF_W-1 -: 8];
   assign last_idx = dbg_q ? IDX_W'(DBG_N - 1) : IDX_W'(NORM_N - 1);
   assign cap      = (state_q == IDLE) && in_valid && !soft_clr;

   // The whole frame (minus checksum) is laid out MSB-first so transmission is a plain left shift.
   always_comb begin
      resp_xor = '0;
      dbg_pay  = '0;
      norm_pay = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         resp_xor ^= in_resp[c*RESP_W +: RESP_W];
         dbg_pay[(NUM_CH-1-c)*RESP_W +: RESP_W] = in_resp[c*RESP_W +: RESP_W];
      end
      norm_pay[PAY_W-1 -: RESP_W] = resp_xor;
      cap_frame.hdr  = HDR_BYTE;
      cap_frame.mode = {in_debug, seq7};
      cap_frame.chal = in_chal;
      cap_frame.pay  = in_debug ? dbg_pay : norm_pay;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      out_data   = '0;
      frame_done = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = !soft_clr;
            if (cap) begin
               state_d = SEND;
            end
         end
         SEND: begin
            out_valid = 1'b1;
            out_data  = cur_byte;
            if (out_ready && (idx_q == last_idx)) begin
               state_d = CKSUM;
            end
         end
         CKSUM: begin
            out_valid = 1'b1;
            out_data  = csum_q;
            if (out_ready) begin
               frame_done = !soft_clr;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Abort overrides any handshake in flight, including the checksum acceptance.
      if (soft_clr) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q  <= '0;
         idx_q  <= '0;
         csum_q <= '0;
         dbg_q  <= 1'b0;
         seq_q  <= '0;
      end else if (soft_clr) begin
         idx_q  <= '0;
         csum_q <= '0;
      end else if (cap) begin
         buf_q  <= cap_frame;
         dbg_q  <= in_debug;
         idx_q  <= '0;
         csum_q <= '0;
      end else if ((state_q == SEND) && out_ready) begin
         buf_q  <= buf_q << 8;
         idx_q  <= idx_q + IDX_W'(1);
         csum_q <= csum_q ^ cur_byte;
      end else if ((state_q == CKSUM) && out_ready) begin
         seq_q  <= seq_q + CNT_W'(1);
         idx_q  <= '0;
         csum_q <= '0;
      end
   end

endmodule

// File: tb/tb_puf_resp_framer.sv
// Bench for puf_resp_framer: directed frames from known vectors plus randomized frames against a byte-queue frame model.
module tb_puf_resp_framer;

   localparam int         NUM_CH = 4;
   localparam int         CHAL_W = 16;
   localparam int         RESP_W = 16;
   localparam int         CNT_W  = 5;
   localparam logic [7:0] HDR    = 8'hA5;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     in_valid = 1'b0;
   logic                     in_ready;
   logic                     in_debug = 1'b0;
   logic [CHAL_W-1:0]        in_chal = '0;
   logic [NUM_CH*RESP_W-1:0] in_resp = '0;
   logic                     soft_clr = 1'b0;
   logic [7:0]               out_data;
   logic                     out_valid;
   logic                     out_ready = 1'b0;
   logic                     frame_done;
   logic [CNT_W-1:0]         seq;

   puf_resp_framer #(
      .NUM_CH(NUM_CH), .CHAL_W(CHAL_W), .RESP_W(RESP_W), .CNT_W(CNT_W), .HDR_BYTE(HDR)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_debug(in_debug), .in_chal(in_chal), .in_resp(in_resp), .soft_clr(soft_clr),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .frame_done(frame_done), .seq(seq)
   );

   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         mseq    = 0;
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];
   int         done_pos;
   int         done_cnt;
   int         first_lat;
   bit         timed_out;

   // Expected frame as a byte list: header, mode, challenge, payload, then XOR of everything before.
   function automatic void build_exp(input logic [CHAL_W-1:0] ch, input logic [NUM_CH*RESP_W-1:0] rs,
                                     input bit dbg, input int s);
      logic [7:0]        ck;
      logic [RESP_W-1:0] x;
      exp_q.delete();
      exp_q.push_back(HDR);
      exp_q.push_back({dbg, 7'(s % (1 << CNT_W))});
      for (int k = CHAL_W/8 - 1; k >= 0; k--) exp_q.push_back(ch[k*8 +: 8]);
      if (dbg) begin
         for (int c = 0; c < NUM_CH; c++)
            for (int b = RESP_W/8 - 1; b >= 0; b--) exp_q.push_back(rs[c*RESP_W + b*8 +: 8]);
      end else begin
         x = '0;
         for (int c = 0; c < NUM_CH; c++) x ^= rs[c*RESP_W +: RESP_W];
         for (int b = RESP_W/8 - 1; b >= 0; b--) exp_q.push_back(x[b*8 +: 8]);
      end
      ck = '0;
      foreach (exp_q[i]) ck ^= exp_q[i];
      exp_q.push_back(ck);
   endfunction

   task automatic start_frame(input logic [CHAL_W-1:0] ch, input logic [NUM_CH*RESP_W-1:0] rs, input bit dbg);
      @(negedge clk);
      in_chal  = ch;
      in_resp  = rs;
      in_debug = dbg;
      in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         #1;
         if (in_ready) break;
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic collect(input int stall_pct, input int max_cyc);
      rx_q.delete();
      done_pos  = -1;
      done_cnt  = 0;
      first_lat = -1;
      timed_out = 1'b1;
      for (int cyc = 0; cyc < max_cyc; cyc++) begin
         @(negedge clk);
         out_ready = ($urandom_range(0, 99) >= stall_pct);
         #1;
         if (out_valid && first_lat < 0) first_lat = cyc;
         if (frame_done) done_cnt++;
         if (out_valid && out_ready) begin
            rx_q.push_back(out_data);
            if (frame_done) begin
               done_pos  = rx_q.size() - 1;
               timed_out = 1'b0;
               break;
            end
         end
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL rst_out_data: got %h want 00", out_data); end
      n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
      n_tests++; if (seq !== '0) begin n_fail++; $display("FAIL rst_seq: got %0d want 0", seq); end
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL post_rst_idle: got valid=%b ready=%b want 0/1", out_valid, in_ready);
      end
      mseq = 0;
   endtask

   task automatic check_fixed(input string nm, input int len, input logic [7:0] want [13], input int want_seq);
      n_tests++; if (timed_out) begin n_fail++; $display("FAIL %s_timeout: got no frame_done want one", nm); end
      n_tests++; if (rx_q.size() != len) begin n_fail++; $display("FAIL %s_len: got %0d want %0d", nm, rx_q.size(), len); end
      for (int i = 0; i < len && i < rx_q.size(); i++) begin
         n_tests++; if (rx_q[i] !== want[i]) begin n_fail++; $display("FAIL %s_byte%0d: got %h want %h", nm, i, rx_q[i], want[i]); end
      end
      n_tests++; if (done_pos != len - 1 || done_cnt != 1) begin
         n_fail++; $display("FAIL %s_done: got pos=%0d cnt=%0d want pos=%0d cnt=1", nm, done_pos, done_cnt, len - 1);
      end
      n_tests++; if (first_lat != 0) begin n_fail++; $display("FAIL %s_hdr_latency: got %0d want 0", nm, first_lat); end
      n_tests++; if (seq !== CNT_W'(want_seq)) begin n_fail++; $display("FAIL %s_seq: got %0d want %0d", nm, seq, want_seq); end
      @(negedge clk);
      n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL %s_idle_after: got ready=%b valid=%b want 1/0", nm, in_ready, out_valid);
      end
   endtask

   task automatic test_normal();
      logic [7:0] want [13];
      want = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'hEE, 8'h11, 8'h7C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      start_frame(16'h1234, {16'h1111, 16'hF0F0, 16'h0F0F, 16'h00FF}, 1'b0);
      collect(0, 100);
      check_fixed("normal", 7, want, 1);
      mseq = 1;
   endtask

   task automatic test_debug();
      logic [7:0] want [13];
      want = '{8'hA5, 8'h81, 8'h12, 8'h34, 8'h00, 8'hFF, 8'h0F, 8'h0F, 8'hF0, 8'hF0, 8'h11, 8'h11, 8'hFD};
      start_frame(16'h1234, {16'h1111, 16'hF0F0, 16'h0F0F, 16'h00FF}, 1'b1);
      collect(0, 100);
      check_fixed("debug", 13, want, 2);
      mseq = 2;
   endtask

   task automatic test_backpressure();
      int  stalls = 0;
      bit  got_done = 1'b0;
      build_exp(16'h1234, {16'h1111, 16'hF0F0, 16'h0F0F, 16'h00FF}, 1'b0, mseq);
      start_frame(16'h1234, {16'h1111, 16'hF0F0, 16'h0F0F, 16'h00FF}, 1'b0);
      rx_q.delete();
      for (int cyc = 0; cyc < 100 && !got_done; cyc++) begin
         @(negedge clk);
         if (rx_q.size() == 3 && stalls < 5) begin out_ready = 1'b0; stalls++; end
         else out_ready = 1'b1;
         #1;
         if (!out_ready) begin
            n_tests++; if (out_valid !== 1'b1 || out_data !== 8'h34) begin
               n_fail++; $display("FAIL bp_hold%0d: got valid=%b data=%h want 1/34", stalls, out_valid, out_data);
            end
         end
         if (out_valid && out_ready) begin
            rx_q.push_back(out_data);
            got_done = frame_done;
         end
      end
      @(posedge clk); #1; out_ready = 1'b1;
      n_tests++; if (!got_done || stalls != 5) begin n_fail++; $display("FAIL bp_complete: got done=%b stalls=%0d want 1/5", got_done, stalls); end
      n_tests++; if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_len: got %0d want %0d", rx_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         n_tests++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
      end
      mseq++;
   endtask

   task automatic test_random();
      logic [CHAL_W-1:0]        ch;
      logic [NUM_CH*RESP_W-1:0] rs;
      bit                       dbg;
      for (int f = 0; f < 20; f++) begin
         ch  = CHAL_W'($urandom());
         rs  = {$urandom(), $urandom()};
         dbg = 1'($urandom_range(0, 1));
         build_exp(ch, rs, dbg, mseq);
         start_frame(ch, rs, dbg);
         collect($urandom_range(0, 60), 500);
         n_tests++; if (timed_out || rx_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rnd%0d_len: got %0d timeout=%b want %0d", f, rx_q.size(), timed_out, exp_q.size());
         end
         for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_tests++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd%0d_byte%0d: got %h want %h", f, i, rx_q[i], exp_q[i]); end
         end
         n_tests++; if (done_cnt != 1 || first_lat != 0) begin
            n_fail++; $display("FAIL rnd%0d_done: got cnt=%0d lat=%0d want 1/0", f, done_cnt, first_lat);
         end
         mseq++;
         n_tests++; if (seq !== CNT_W'(mseq % 32)) begin n_fail++; $display("FAIL rnd%0d_seq: got %0d want %0d", f, seq, mseq % 32); end
      end
   endtask

   task automatic test_abort();
      logic [CHAL_W-1:0]        ch;
      logic [NUM_CH*RESP_W-1:0] rs;
      int                       dones = 0;
      bit                       aborted = 1'b0;
      ch = CHAL_W'($urandom());
      rs = {$urandom(), $urandom()};
      start_frame(ch, rs, 1'b1);
      rx_q.delete();
      for (int cyc = 0; cyc < 100 && !aborted; cyc++) begin
         @(negedge clk);
         out_ready = 1'b1;
         #1;
         if (frame_done) dones++;
         if (rx_q.size() == 4) begin
            soft_clr = 1'b1;
            aborted  = 1'b1;
         end else if (out_valid) begin
            rx_q.push_back(out_data);
         end
      end
      @(posedge clk); #1; soft_clr = 1'b0;
      @(negedge clk);
      n_tests++; if (!aborted || out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b want 0", out_valid); end
      n_tests++; if (seq !== CNT_W'(mseq % 32)) begin n_fail++; $display("FAIL abort_seq: got %0d want %0d", seq, mseq % 32); end
      n_tests++; if (dones != 0 || frame_done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %0d pulses want 0", dones); end
      // soft_clr must beat a simultaneous capture request in IDLE.
      in_valid = 1'b1; soft_clr = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0; soft_clr = 1'b0;
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_idle_capture: got valid=%b want 0", out_valid); end
      ch = CHAL_W'($urandom());
      rs = {$urandom(), $urandom()};
      build_exp(ch, rs, 1'b0, mseq);
      start_frame(ch, rs, 1'b0);
      collect(0, 100);
      n_tests++; if (timed_out || rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL abort_next_len: got %0d want %0d", rx_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         n_tests++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL abort_next_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
      end
      mseq++;
   endtask

   task automatic test_reset_midframe();
      logic [CHAL_W-1:0]        ch;
      logic [NUM_CH*RESP_W-1:0] rs;
      bit                       hit = 1'b0;
      ch = CHAL_W'($urandom());
      rs = {$urandom(), $urandom()};
      build_exp(ch, rs, 1'b0, mseq);
      start_frame(ch, rs, 1'b0);
      rx_q.delete();
      for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
         @(negedge clk);
         if (rx_q.size() == 6) begin
            out_ready = 1'b0;
            #1;
            n_tests++; if (out_valid !== 1'b1 || out_data !== exp_q[6]) begin
               n_fail++; $display("FAIL rstmid_cksum: got valid=%b data=%h want 1/%h", out_valid, out_data, exp_q[6]);
            end
            rst_n = 1'b0;
            #1;
            hit = 1'b1;
         end else begin
            out_ready = 1'b1;
            #1;
            if (out_valid) rx_q.push_back(out_data);
         end
      end
      n_tests++; if (!hit || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_async: got valid=%b ready=%b want 0/1", out_valid, in_ready);
      end
      n_tests++; if (seq !== '0 || frame_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_seq: got seq=%0d done=%b want 0/0", seq, frame_done); end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      mseq = 0;
      build_exp(ch, rs, 1'b0, mseq);
      start_frame(ch, rs, 1'b0);
      collect(0, 100);
      n_tests++; if (rx_q.size() < 2 || rx_q[0] !== HDR || rx_q[1] !== 8'h00) begin
         n_fail++; $display("FAIL rstmid_next: got size=%0d want header A5 mode 00", rx_q.size());
      end
      n_tests++; if (rx_q.size() != exp_q.size() || rx_q[rx_q.size()-1] !== exp_q[exp_q.size()-1]) begin
         n_fail++; $display("FAIL rstmid_next_cksum: got size=%0d want %0d with matching checksum", rx_q.size(), exp_q.size());
      end
      mseq = 1;
   endtask

   task automatic test_seq_wrap();
      int         captured = 0;
      int         finished = 0;
      logic [7:0] b;
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      exp_q.delete();
      for (int cyc = 0; cyc < 2000 && finished < 33; cyc++) begin
         @(negedge clk);
         in_valid  = (captured < 33);
         in_chal   = CHAL_W'($urandom());
         in_resp   = {$urandom(), $urandom()};
         in_debug  = 1'b0;
         out_ready = 1'b1;
         #1;
         if (in_valid && in_ready) begin
            n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_busy_capture: got ready=1 with %0d bytes pending want 0", exp_q.size()); end
            build_exp(in_chal, in_resp, 1'b0, captured);
            captured++;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++; $display("FAIL wrap_extra_byte: got %h want none", out_data);
            end else begin
               b = exp_q.pop_front();
               n_tests++; if (out_data !== b) begin n_fail++; $display("FAIL wrap_f%0d_byte: got %h want %h", finished, out_data, b); end
               n_tests++; if (frame_done !== (exp_q.size() == 0)) begin
                  n_fail++; $display("FAIL wrap_f%0d_done: got %b want %b", finished, frame_done, exp_q.size() == 0);
               end
               if (frame_done) finished++;
            end
         end else if (frame_done) begin
            n_tests++; n_fail++; $display("FAIL wrap_spurious_done: got 1 want 0");
         end
      end
      in_valid = 1'b0;
      @(negedge clk);
      n_tests++; if (finished != 33) begin n_fail++; $display("FAIL wrap_frames: got %0d want 33", finished); end
      n_tests++; if (seq !== CNT_W'(1)) begin n_fail++; $display("FAIL wrap_seq: got %0d want 1", seq); end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_debug();
      test_backpressure();
      test_random();
      test_abort();
      test_reset_midframe();
      test_seq_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion want finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
